fifo_wr_arbiter: RTL and testbench

Round-robin write-port arbiter that shares the single write port of one `fifo` instance between `NUM_REQ` requesters. Each requester presents a valid/ready stream. The arbiter grants one requester at a time, with an optional burst lock of up to `MAX_BURST` consecutive writes, and never writes while `fifo_full` is high. It runs in the FIFO write-clock domain: `clk` connects to the FIFO `wr_clk`, and `wr_en`/`data_wr` drive the FIFO directly.

---
 rtl/fifo_arb_pkg.sv | 28 ++
 rtl/fifo_rr_pick.sv | 29 ++
 rtl/fifo_wr_arbiter.sv | 109 ++++++++++
 tb/tb_fifo_wr_arbiter.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package fifo_arb_pkg;

  // Widest requester vector the rotate helper accepts.
  localparam int MAX_REQ = 32;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Returns the first set bit of valid[0..n-1], scanning from last+1 upward
  // with wrap. If none is set, returns last. Iterating from the farthest
  // distance down to the nearest makes the nearest hit the final assignment.
  function automatic int rr_next(input logic [MAX_REQ-1:0] valid,
                                 input int last,
                                 input int n);
    int k;
    rr_next = last;
    for (int i = n; i >= 1; i--) begin
      k = (last + i) % n;
      if (valid[k[4:0]]) rr_next = k;
    end
  endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Rotate-priority picker: the first valid requester after last_grant, with wrap.
// Latency: purely combinational.
// Backpressure: none; found=0 when no requester is valid (idx then echoes last_grant).
// Ports: valid (per-requester), last_grant (rotation origin) -> found, idx.
module fifo_rr_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         valid,
  input  logic [$clog2(NUM_REQ)-1:0] last_grant,
  output logic                       found,
  output logic [$clog2(NUM_REQ)-1:0] idx
);

  localparam int IW = $clog2(NUM_REQ);

  logic [MAX_REQ-1:0] v_ext;
  int                 pick;

  always_comb begin
    v_ext                = '0;
    v_ext[NUM_REQ-1:0]   = valid;
    pick                 = rr_next(v_ext, int'(last_grant), NUM_REQ);
    found                = |valid;
    idx                  = IW'(pick);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ valid/ready streams.
// Latency: zero; a word is accepted and written to the FIFO on the same edge.
// Backpressure: fifo_full blocks every transfer that cycle; a locked owner stalls in place.
// Ports: req_valid/req_data/req_ready per requester; fifo_full in; wr_en/data_wr to the
//        FIFO; grant_id (current or last grant) and locked (burst in progress) for status.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         data_wr,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          locked
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam bit LOCK_EN = (MAX_BURST > 1);

  arb_state_t    state;
  logic [IW-1:0] owner;
  logic [IW-1:0] last_grant;
  logic [CW-1:0] burst_cnt;

  logic          found;
  logic [IW-1:0] win;
  logic [IW-1:0] sel;
  logic          xfer;

  fifo_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .valid      (req_valid),
    .last_grant (last_grant),
    .found      (found),
    .idx        (win)
  );

  // Which requester is presented this cycle and whether its word moves.
  always_comb begin
    sel  = last_grant;
    xfer = 1'b0;
    if (state == LOCK) begin
      sel  = owner;
      xfer = req_valid[owner] & ~fifo_full;
    end else begin
      sel  = found ? win : last_grant;
      xfer = found & ~fifo_full;
    end
  end

  // Outputs are gated by rst_n so they drop the instant reset asserts,
  // independent of the register reset values (last_grant resets non-zero).
  always_comb begin
    wr_en     = xfer & rst_n;
    req_ready = wr_en ? (NUM_REQ'(1) << sel) : '0;
    data_wr   = wr_en ? req_data[sel*DATA_WIDTH +: DATA_WIDTH] : '0;
    grant_id  = rst_n ? sel : '0;
    locked    = rst_n & (state == LOCK);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      burst_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found && !fifo_full) begin
            if (LOCK_EN) begin
              state     <= LOCK;
              owner     <= win;
              burst_cnt <= CW'(1);
            end else begin
              last_grant <= win;
            end
          end
        end
        LOCK: begin
          if (!req_valid[owner]) begin
            // Owner dropped: this cycle is the bubble, release the lock.
            state      <= IDLE;
            last_grant <= owner;
            burst_cnt  <= '0;
          end else if (!fifo_full) begin
            if (burst_cnt == CW'(MAX_BURST - 1)) begin
              state      <= IDLE;
              last_grant <= owner;
              burst_cnt  <= '0;
            end else begin
              burst_cnt <= burst_cnt + CW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (MAX_BURST=4 and MAX_BURST=1 instances).
// Latency: n/a.
// Backpressure: fifo_full is driven from a bench-side occupancy plan.
module tb_fifo_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [3:0]  req_valid1 = '0;
  logic [31:0] req_data = '0;
  logic        fifo_full = 1'b0;

  logic [3:0]  req_ready, req_ready1;
  logic        wr_en, wr_en1;
  logic [7:0]  data_wr, data_wr1;
  logic [1:0]  grant_id, grant_id1;
  logic        locked, locked1;

  int n_chk = 0;
  int n_fail = 0;
  int seq[4] = '{0, 0, 0, 0};

  typedef struct packed {
    logic       wr;
    logic [1:0] id;
    logic       lk;
    logic [7:0] dat;
    logic [3:0] rdy;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .fifo_full (fifo_full),
    .wr_en     (wr_en),
    .data_wr   (data_wr),
    .grant_id  (grant_id),
    .locked    (locked)
  );

  fifo_wr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .MAX_BURST(1)) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid1),
    .req_data  (req_data),
    .req_ready (req_ready1),
    .fifo_full (1'b0),
    .wr_en     (wr_en1),
    .data_wr   (data_wr1),
    .grant_id  (grant_id1),
    .locked    (locked1)
  );

  function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endfunction

  // One clock of stimulus: drive inputs, queue the expected outcome, sample at
  // the falling edge, then let the rising edge commit. which selects the DUT.
  task automatic cyc(input bit which, input logic [3:0] vld, input logic full,
                     input logic ewr, input logic [1:0] eid, input logic elk);
    exp_t e;
    exp_t g;
    for (int k = 0; k < 4; k++) req_data[k*8 +: 8] = 8'(k*16 + seq[k]);
    if (which) begin
      req_valid  = '0;
      req_valid1 = vld;
    end else begin
      req_valid  = vld;
      req_valid1 = '0;
    end
    fifo_full = full;
    e.wr  = ewr;
    e.id  = eid;
    e.lk  = elk;
    e.dat = ewr ? 8'(int'(eid)*16 + seq[eid]) : 8'h00;
    e.rdy = ewr ? (4'b0001 << eid) : 4'b0000;
    sb.push_back(e);
    if (ewr) seq[eid]++;
    @(negedge clk);
    g = sb.pop_front();
    if (which) begin
      chk("wr_en1",     32'(wr_en1),     32'(g.wr));
      chk("grant_id1",  32'(grant_id1),  32'(g.id));
      chk("locked1",    32'(locked1),    32'(g.lk));
      chk("data_wr1",   32'(data_wr1),   32'(g.dat));
      chk("req_ready1", 32'(req_ready1), 32'(g.rdy));
    end else begin
      chk("wr_en",      32'(wr_en),      32'(g.wr));
      chk("grant_id",   32'(grant_id),   32'(g.id));
      chk("locked",     32'(locked),     32'(g.lk));
      chk("data_wr",    32'(data_wr),    32'(g.dat));
      chk("req_ready",  32'(req_ready),  32'(g.rdy));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset held with everyone requesting: all outputs must be 0.
    req_valid = 4'hF;
    #3;
    chk("rst_wr",    32'(wr_en),     32'd0);
    chk("rst_rdy",   32'(req_ready), 32'd0);
    chk("rst_gid",   32'(grant_id),  32'd0);
    chk("rst_lock",  32'(locked),    32'd0);
    chk("rst_dat",   32'(data_wr),   32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = '0;
    #1;
    // Idle after reset: grant_id shows last_grant = NUM_REQ-1.
    chk("idle_gid",  32'(grant_id),  32'd3);
    chk("idle_wr",   32'(wr_en),     32'd0);
    @(posedge clk);
    #1;

    // All requesting, never full: 4-write bursts 0,1,2 with no bubbles.
    for (int b = 0; b < 3; b++)
      for (int j = 0; j < 4; j++)
        cyc(0, 4'hF, 1'b0, 1'b1, 2'(b), j != 0);

    // Only req 2; it drops after 2 writes -> bubble, then scan starts at 3.
    cyc(0, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    cyc(0, 4'b0100, 1'b0, 1'b1, 2'd2, 1'b1);
    cyc(0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1);
    cyc(0, 4'b1011, 1'b0, 1'b1, 2'd3, 1'b0);
    cyc(0, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b1);
    cyc(0, 4'b0000, 1'b0, 1'b0, 2'd3, 1'b0);

    // Req 1 burst stalled 5 cycles by full at burst_cnt=2; others valid but ignored.
    cyc(0, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    cyc(0, 4'b0010, 1'b0, 1'b1, 2'd1, 1'b1);
    repeat (5) cyc(0, 4'hF, 1'b1, 1'b0, 2'd1, 1'b1);
    cyc(0, 4'hF, 1'b0, 1'b1, 2'd1, 1'b1);
    cyc(0, 4'hF, 1'b0, 1'b1, 2'd1, 1'b1);
    cyc(0, 4'hF, 1'b0, 1'b1, 2'd2, 1'b0);
    cyc(0, 4'b0000, 1'b0, 1'b0, 2'd2, 1'b1);

    // Full in IDLE blocks the transfer, then the winner goes on the first free cycle.
    cyc(0, 4'b0001, 1'b1, 1'b0, 2'd0, 1'b0);
    cyc(0, 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);
    cyc(0, 4'b0000, 1'b0, 1'b0, 2'd0, 1'b1);

    // Fill an empty 12-deep FIFO: exactly 12 writes (reqs 1,2,3), then held off by full.
    for (int b = 1; b < 4; b++)
      for (int j = 0; j < 4; j++)
        cyc(0, 4'hF, 1'b0, 1'b1, 2'(b), j != 0);
    repeat (3) cyc(0, 4'hF, 1'b1, 1'b0, 2'd0, 1'b0);

    // FIFO drained; start a burst of req 0 and reset in the middle of it.
    cyc(0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0);
    cyc(0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr",   32'(wr_en),     32'd0);
    chk("mid_rst_rdy",  32'(req_ready), 32'd0);
    chk("mid_rst_gid",  32'(grant_id),  32'd0);
    chk("mid_rst_lock", 32'(locked),    32'd0);
    chk("mid_rst_dat",  32'(data_wr),   32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(0, 4'hF, 1'b0, 1'b1, 2'd0, 1'b0);

    // MAX_BURST=1 instance: reqs 0 and 3 alternate, never locked.
    cyc(1, 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0);
    cyc(1, 4'b1001, 1'b0, 1'b1, 2'd3, 1'b0);
    cyc(1, 4'b1001, 1'b0, 1'b1, 2'd0, 1'b0);
    cyc(1, 4'b1001, 1'b0, 1'b1, 2'd3, 1'b0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
